// File: rtl/pb_conditioner_if.sv
// Button-conditioner bus: raw pins and frame tick in, conditioned button views out.
// The conditioner uses the slave modport; the consumer/driver side uses master.
interface pb_conditioner_if #(
   parameter int N_BTN = 8
);
   logic [N_BTN-1:0] pb_raw;
   logic             frame_tick;
   logic [N_BTN-1:0] pb_level;
   logic [N_BTN-1:0] pb_rise;
   logic [N_BTN-1:0] pb_fall;
   logic [N_BTN-1:0] pb_frame;
   logic [N_BTN-1:0] ctrl;

   modport master (
      output pb_raw,
      output frame_tick,
      input  pb_level,
      input  pb_rise,
      input  pb_fall,
      input  pb_frame,
      input  ctrl
   );

   modport slave (
      input  pb_raw,
      input  frame_tick,
      output pb_level,
      output pb_rise,
      output pb_fall,
      output pb_frame,
      output ctrl
   );
endinterface

// File: rtl/pb_conditioner.sv
// Push-button conditioner: sync, debounce, edge detect, per-frame press latch
// and per-player (group of 4) lowest-index one-hot arbitration.
module pb_conditioner #(
   parameter int N_BTN      = 8,
   parameter int DEB_CYCLES = 250000,
   parameter int CNT_W      = 18
) (
   input logic             clk,
   input logic             rst,
   pb_conditioner_if.slave pb
);

   localparam int unsigned     N_GRP   = N_BTN / 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] fall;
   logic [N_BTN-1:0] frame;

   logic [N_BTN-1:0] level_n;
   logic [N_BTN-1:0] rise_n;
   logic [N_BTN-1:0] fall_n;
   logic [N_BTN-1:0] frame_n;
   logic [N_BTN-1:0] ctrl_c;
   logic [3:0]       grp;

   logic [CNT_W-1:0] cnt   [N_BTN];
   logic [CNT_W-1:0] cnt_n [N_BTN];

   // Debounce next-state; the >= compare keeps the counter from ever wrapping.
   always_comb begin
      level_n = level;
      rise_n  = '0;
      fall_n  = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         cnt_n[i] = '0;
         if (s2[i] != level[i]) begin
            if (cnt[i] >= CNT_MAX) begin
               level_n[i] = s2[i];
               rise_n[i]  = s2[i];
               fall_n[i]  = ~s2[i];
            end else begin
               cnt_n[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
      // A tap during the tick cycle survives into the new frame.
      frame_n = pb.frame_tick ? (level_n | rise_n) : (frame | rise_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         level <= '0;
         rise  <= '0;
         fall  <= '0;
         frame <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1    <= pb.pb_raw;
         s2    <= s1;
         level <= level_n;
         rise  <= rise_n;
         fall  <= fall_n;
         frame <= frame_n;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt[i] <= cnt_n[i];
         end
      end
   end

   // x & -x isolates the lowest set bit of each 4-bit player group.
   always_comb begin
      ctrl_c = '0;
      grp    = '0;
      for (int unsigned g = 0; g < N_GRP; g++) begin
         grp               = frame[4*g +: 4];
         ctrl_c[4*g +: 4]  = grp & (~grp + 4'd1);
      end
   end

   assign pb.pb_level = level;
   assign pb.pb_rise  = rise;
   assign pb.pb_fall  = fall;
   assign pb.pb_frame = frame;
   assign pb.ctrl     = ctrl_c;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed button scenarios plus random stimulus,
// all compared every cycle against a sample-window reference model.
module tb_pb_conditioner;

   localparam int N   = 8;
   localparam int DEB = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pb_conditioner_if #(.N_BTN(N)) bus ();

   pb_conditioner #(
      .N_BTN      (N),
      .DEB_CYCLES (DEB),
      .CNT_W      (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .pb  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: sync delay line, last DEB post-sync samples, and per-bit
   // count of samples seen since that bit last changed (or since reset).
   logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_frame;
   logic [N-1:0] hist[$];
   int           since [N];

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] model_ctrl(input logic [N-1:0] f);
      logic [N-1:0] r;
      r = '0;
      for (int g = 0; g < N / 4; g++) begin
         for (int b = 0; b < 4; b++) begin
            if (f[4*g+b]) begin
               r[4*g+b] = 1'b1;
               break;
            end
         end
      end
      return r;
   endfunction

   task automatic model_edge();
      logic [N-1:0] samp, ln, rn, fn;
      bit           all_diff;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_frame = '0;
         hist.delete();
         for (int i = 0; i < N; i++) since[i] = 0;
      end else begin
         samp = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.pb_raw;
         hist.push_back(samp);
         if (hist.size() > DEB) void'(hist.pop_front());
         ln = m_level; rn = '0; fn = '0;
         for (int i = 0; i < N; i++) begin
            since[i]++;
            if (since[i] >= DEB) begin
               all_diff = 1'b1;
               foreach (hist[k]) if (hist[k][i] == m_level[i]) all_diff = 1'b0;
               if (all_diff) begin
                  ln[i] = ~m_level[i];
                  rn[i] = ln[i];
                  fn[i] = ~ln[i];
                  since[i] = 0;
               end
            end
         end
         m_frame = bus.frame_tick ? (ln | rn) : (m_frame | rn);
         m_level = ln; m_rise = rn; m_fall = fn;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("level", bus.pb_level, m_level);
      check("rise",  bus.pb_rise,  m_rise);
      check("fall",  bus.pb_fall,  m_fall);
      check("frame", bus.pb_frame, m_frame);
      check("ctrl",  bus.ctrl,     model_ctrl(m_frame));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_frame();
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
   endtask

   logic [N-1:0] raw;

   initial begin
      total = 0; bad = 0;
      rst = 1'b1;
      bus.pb_raw = 8'hFF;
      bus.frame_tick = 1'b0;
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_frame = '0;
      for (int i = 0; i < N; i++) since[i] = 0;

      // 1. reset with all buttons held, then 2+DEB latency
      ticks(2);
      check("rst_level", bus.pb_level, 8'h00);
      check("rst_frame", bus.pb_frame, 8'h00);
      check("rst_ctrl",  bus.ctrl,     8'h00);
      rst = 1'b0;
      ticks(5);
      check("rst_lat5", bus.pb_level, 8'h00);
      tick();
      check("rst_lat6", bus.pb_level, 8'hFF);
      check("rst_rise", bus.pb_rise,  8'hFF);
      bus.pb_raw = 8'h00;
      ticks(8);
      pulse_frame();
      check("clear_frame", bus.pb_frame, 8'h00);

      // 2. bounce on bit 0
      bus.pb_raw = 8'h01; ticks(2);
      bus.pb_raw = 8'h00; ticks(2);
      bus.pb_raw = 8'h01;
      ticks(5);
      check("bounce_lat5", bus.pb_level & 8'h01, 8'h00);
      tick();
      check("bounce_lat6", bus.pb_level & 8'h01, 8'h01);
      check("bounce_rise", bus.pb_rise & 8'h01, 8'h01);
      tick();
      check("bounce_rise_once", bus.pb_rise & 8'h01, 8'h00);
      bus.pb_raw = 8'h00;
      ticks(8);
      pulse_frame();

      // 3. short tap on bit 1, held in the frame latch until the next tick
      bus.pb_raw = 8'h02; ticks(8);
      bus.pb_raw = 8'h00; ticks(10);
      check("tap_level_gone", bus.pb_level & 8'h02, 8'h00);
      check("tap_frame_held", bus.pb_frame & 8'h02, 8'h02);
      check("tap_ctrl_held",  bus.ctrl, 8'h02);
      pulse_frame();
      check("tap_frame_clr", bus.pb_frame & 8'h02, 8'h00);
      check("tap_ctrl_clr",  bus.ctrl, 8'h00);

      // 4. arbitration, lowest index per group
      bus.pb_raw = 8'b0110_1100; ticks(8);
      pulse_frame();
      check("arb_ctrl",  bus.ctrl,     8'b0010_0100);
      check("arb_level", bus.pb_level, 8'b0110_1100);

      // 5. release of bit 7
      bus.pb_raw = 8'b1110_1100; ticks(8);
      bus.pb_raw = 8'b0110_1100;
      ticks(5);
      check("rel_lat5", bus.pb_fall & 8'h80, 8'h00);
      tick();
      check("rel_fall", bus.pb_fall & 8'h80, 8'h80);
      tick();
      check("rel_fall_once", bus.pb_fall & 8'h80, 8'h00);
      check("rel_frame_held", bus.pb_frame & 8'h80, 8'h80);
      pulse_frame();
      check("rel_frame_clr", bus.pb_frame & 8'h80, 8'h00);

      // 6. reset while bit 3 is mid-count
      bus.pb_raw = 8'h00; ticks(8);
      pulse_frame();
      bus.pb_raw = 8'h08; ticks(4);
      rst = 1'b1; tick();
      rst = 1'b0;
      ticks(5);
      check("midrst_lat5", bus.pb_level & 8'h08, 8'h00);
      tick();
      check("midrst_lat6", bus.pb_level & 8'h08, 8'h08);

      // random phase: slowly changing buttons, sparse ticks, rare resets
      raw = bus.pb_raw;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 6) == 0) raw[i] = ~raw[i];
         end
         bus.pb_raw     = raw;
         bus.frame_tick = ($urandom_range(0, 12) == 0);
         rst            = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      bus.frame_tick = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
